comparatore_3bit_driver: RTL and testbench

COMPARATORE_3BIT_DRIVER -- requirements
Module: comparatore_3bit_driver

---
 rtl/comparatore_3bit_driver.sv | 120 ++++++++++++
 tb/tb_comparatore_3bit_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/comparatore_3bit_driver.sv
// rtl/comparatore_3bit_driver.sv - exhaustive operand scanner for a 3-bit comparator under test
// Walks a, b, c through every triple (or a,b with c fixed) and tallies the comparator result.
module comparatore_3bit_driver #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fix_c,
  input  logic [2:0] c_cfg,
  input  logic       cmp_out,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [2:0] c,
  output logic       busy,
  output logic       done,
  output logic [9:0] ones_cnt,
  output logic [8:0] first_hit,
  output logic       hit_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

  state_t      state, nstate;
  logic [8:0]  idx;
  logic [3:0]  settle_cnt;
  logic        mode;
  logic [2:0]  c_lat;
  logic        sample;
  logic        last;
  logic [8:0]  nxt_idx;
  logic [8:0]  nxt_triple;

  // A sample happens on the edge that ends the SETTLE-cycle hold of the current triple.
  assign sample     = (state == RUN) && (settle_cnt == 4'(SETTLE - 1));
  assign last       = mode ? (idx == 9'd63) : (idx == 9'd511);
  assign nxt_idx    = idx + 9'd1;
  assign nxt_triple = mode ? {nxt_idx[5:3], nxt_idx[2:0], c_lat} : nxt_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (sample && last) nstate = DONE_S;
      DONE_S:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      mode       <= 1'b0;
      c_lat      <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      ones_cnt   <= '0;
      first_hit  <= '0;
      hit_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode       <= fix_c;
            c_lat      <= c_cfg;
            idx        <= '0;
            settle_cnt <= '0;
            a          <= '0;
            b          <= '0;
            c          <= fix_c ? c_cfg : 3'd0;
            ones_cnt   <= '0;
            first_hit  <= '0;
            hit_valid  <= 1'b0;
          end
        end
        RUN: begin
          if (sample) begin
            settle_cnt <= '0;
            if (cmp_out) begin
              // Count cannot exceed 512, so the guard only protects against wrap.
              if (ones_cnt != 10'd1023) ones_cnt <= ones_cnt + 10'd1;
              if (!hit_valid) begin
                first_hit <= {a, b, c};
                hit_valid <= 1'b1;
              end
            end
            if (last) begin
              a <= '0;
              b <= '0;
              c <= '0;
            end else begin
              idx       <= nxt_idx;
              {a, b, c} <= nxt_triple;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: begin
          a <= '0;
          b <= '0;
          c <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparatore_3bit_driver.sv
// tb/tb_comparatore_3bit_driver.sv - table-driven bench for comparatore_3bit_driver
// A small behavioural comparator model answers the DUT; expectations are hand-computed.
module tb_comparatore_3bit_driver;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fix_c;
  logic [2:0] c_cfg;
  logic       cmp_out;
  logic [2:0] a, b, c;
  logic       busy, done;
  logic [9:0] ones_cnt;
  logic [8:0] first_hit;
  logic       hit_valid;

  int model;
  int total = 0;
  int passed = 0;

  comparatore_3bit_driver #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .fix_c(fix_c), .c_cfg(c_cfg),
    .cmp_out(cmp_out), .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .ones_cnt(ones_cnt), .first_hit(first_hit), .hit_valid(hit_valid)
  );

  always #5 clk = ~clk;

  // 0: never, 1: always, 2: only a=1,b=7, 3: a>b
  always_comb begin
    case (model)
      0:       cmp_out = 1'b0;
      1:       cmp_out = 1'b1;
      2:       cmp_out = (a == 3'd1) && (b == 3'd7);
      3:       cmp_out = (a > b);
      default: cmp_out = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic       fix;
    logic [2:0] cc;
    int         mdl;
    int         ones;
    logic [8:0] first;
    logic       hv;
    int         len;
    bit         disturb;
  } vec_t;

  task automatic run_scan(input logic fx, input logic [2:0] cc, input int mdl, input bit disturb,
                          output int len, output int seq_err, output int done_seen, output logic end_ok);
    logic [8:0] k;
    logic [8:0] exp;
    model = mdl;
    @(negedge clk);
    fix_c = fx;
    c_cfg = cc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 0;
    seq_err = 0;
    done_seen = 0;
    while (busy && len < 2000) begin
      k   = 9'(len / SETTLE);
      exp = fx ? {k[5:3], k[2:0], cc} : k;
      if ({a, b, c} !== exp) seq_err++;
      if (done) done_seen++;
      if (disturb && len == 10) begin
        start = 1'b1;
        c_cfg = ~cc;
      end
      if (disturb && len == 11) start = 1'b0;
      if (disturb && len >= 10) fix_c = ~fix_c;
      len++;
      @(negedge clk);
    end
    start  = 1'b0;
    fix_c  = fx;
    c_cfg  = cc;
    end_ok = (done === 1'b1) && ({a, b, c} === 9'd0) && (busy === 1'b0);
    @(negedge clk);
    end_ok = end_ok && (done === 1'b0) && (busy === 1'b0);
  endtask

  vec_t vt[7];
  int   len, seq_err, done_seen, tmo;
  logic end_ok;
  logic [9:0] held;

  initial begin
    vt[0] = '{1'b0, 3'd0, 1, 512, 9'd0,                      1'b1, 512*SETTLE, 1'b0};
    vt[1] = '{1'b0, 3'd0, 0, 0,   9'd0,                      1'b0, 512*SETTLE, 1'b0};
    vt[2] = '{1'b1, 3'd5, 2, 1,   {3'b001, 3'b111, 3'b101},  1'b1, 64*SETTLE,  1'b0};
    vt[3] = '{1'b1, 3'd0, 3, 28,  {3'b001, 3'b000, 3'b000},  1'b1, 64*SETTLE,  1'b0};
    vt[4] = '{1'b1, 3'd3, 1, 64,  {3'b000, 3'b000, 3'b011},  1'b1, 64*SETTLE,  1'b0};
    vt[5] = '{1'b0, 3'd0, 3, 224, {3'b001, 3'b000, 3'b000},  1'b1, 512*SETTLE, 1'b0};
    vt[6] = '{1'b1, 3'd0, 3, 28,  {3'b001, 3'b000, 3'b000},  1'b1, 64*SETTLE,  1'b1};

    model = 0;
    start = 1'b0;
    fix_c = 1'b0;
    c_cfg = 3'd0;
    rst   = 1'b1;
    #3;
    chk("reset_abc",   {23'd0, a, b, c}, 32'd0);
    chk("reset_flags", {29'd0, busy, done, hit_valid}, 32'd0);
    chk("reset_ones",  {22'd0, ones_cnt}, 32'd0);
    chk("reset_first", {23'd0, first_hit}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_scan(vt[i].fix, vt[i].cc, vt[i].mdl, vt[i].disturb, len, seq_err, done_seen, end_ok);
      chk($sformatf("v%0d_len", i),     len, vt[i].len);
      chk($sformatf("v%0d_seq", i),     seq_err, 0);
      chk($sformatf("v%0d_nodone", i),  done_seen, 0);
      chk($sformatf("v%0d_donepls", i), {31'd0, end_ok}, 32'd1);
      chk($sformatf("v%0d_ones", i),    {22'd0, ones_cnt}, vt[i].ones);
      chk($sformatf("v%0d_first", i),   {23'd0, first_hit}, {23'd0, vt[i].first});
      chk($sformatf("v%0d_hv", i),      {31'd0, hit_valid}, {31'd0, vt[i].hv});
    end

    // Results hold in IDLE, and start during the DONE cycle is ignored
    model = 3;
    @(negedge clk);
    fix_c = 1'b1;
    c_cfg = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo = 0;
    while (!done && tmo < 500) begin
      tmo++;
      @(negedge clk);
    end
    chk("dn_reached", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dn_start_ignored", {30'd0, busy, done}, 32'd0);
    held = ones_cnt;
    repeat (5) @(negedge clk);
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);
    chk("idle_hold_ones", {22'd0, ones_cnt}, 32'd28);
    chk("idle_hold_same", {22'd0, ones_cnt}, {22'd0, held});

    // Asynchronous reset mid-scan
    model = 1;
    fix_c = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_abc",   {23'd0, a, b, c}, 32'd0);
    chk("rst_async_flags", {29'd0, busy, done, hit_valid}, 32'd0);
    chk("rst_async_ones",  {22'd0, ones_cnt}, 32'd0);
    chk("rst_async_first", {23'd0, first_hit}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);
    run_scan(1'b0, 3'd0, 1, 1'b0, len, seq_err, done_seen, end_ok);
    chk("post_rst_len",  len, 512*SETTLE);
    chk("post_rst_seq",  seq_err, 0);
    chk("post_rst_done", {31'd0, end_ok}, 32'd1);
    chk("post_rst_ones", {22'd0, ones_cnt}, 32'd512);
    chk("post_rst_hv",   {31'd0, hit_valid}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
